uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter: OSR, 16, sample ticks per bit; SHALL be even and >= 4.
REQ-002 Port: clk  input  1  single clock; all logic SHALL be clocked on its rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: rx_data_sample  input  1  one-clk strobe at OSR x baud rate; all bit timing SHALL advance only on this strobe.
REQ-005 Port: rx_en  input  1  receiver enable.
REQ-006 Port: no_parity  input  1  1 = frame has no parity bit.
REQ-007 Port: ev_parity  input  1  1 = even parity, 0 = odd parity; ignored when no_parity=1.
REQ-008 Port: rxd  input  1  asynchronous serial line, idle high, LSB first.
REQ-009 Port: rx_rd  input  1  one-clk read acknowledge from consumer.
REQ-010 Port: rx_data  output  8  last received byte.
REQ-011 Port: rx_valid  output  1  one-clk pulse per completed frame.
REQ-012 Port: rx_ready  output  1  unread byte held in rx_data.
REQ-013 Port: parity_err, frame_err, overrun_err  output  1 each  error flags for the frame in rx_data.
REQ-014 Port: rx_busy  output  1  high whenever state is not RX_IDLE.

Function
REQ-015 rxd SHALL pass through a 2-flop synchronizer (rxd_s); the FSM SHALL use only rxd_s.
REQ-016 States SHALL be RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP; a tick counter (0..OSR-1) and a bit counter (0..7) SHALL be kept.
REQ-017 RX_IDLE: on a strobe with rx_en=1 and rxd_s=0 -> RX_START, tick counter cleared.
REQ-018 RX_START: tick counter increments per strobe; at count OSR/2-1, rxd_s=0 -> RX_DATA with both counters cleared; rxd_s=1 -> RX_IDLE (false start, no outputs change).
REQ-019 RX_DATA: at tick count OSR-1, rxd_s SHALL be shifted in as bit[bit counter] (LSB first) and the tick counter wraps to 0; after bit 7 -> RX_PARITY if no_parity=0, else RX_STOP.
REQ-020 RX_PARITY: at tick count OSR-1, the sampled bit is checked: error if XOR(8 data bits, parity bit) != 0 (even) or != 1 (odd); -> RX_STOP.
REQ-021 RX_STOP: at tick count OSR-1, the stop bit is sampled and the state SHALL go to RX_IDLE in the same clk (next start detectable from mid-stop-bit).
REQ-022 Completion edge (stop sampled): rx_data <= assembled byte; rx_valid=1 for exactly that one clk; rx_ready <= 1; parity_err <= parity check result (0 when no_parity=1); frame_err <= (stop bit == 0).
REQ-023 Completion while rx_ready=1 and rx_rd=0 SHALL set overrun_err and overwrite rx_data.
REQ-024 rx_rd=1 SHALL clear rx_ready and overrun_err next clk; rx_rd coincident with completion: completion wins (rx_ready=1, no overrun).
REQ-025 parity_err and frame_err SHALL hold until the next completion.
REQ-026 no_parity and ev_parity SHALL be sampled at RX_START->RX_DATA and held for the frame.
REQ-027 rx_en=0 in any state SHALL force RX_IDLE and clear counters next clk; partial frame discarded, no rx_valid; rx_data and flags retained.
REQ-028 Without strobes the FSM and counters SHALL hold.
REQ-029 Latency: rx_valid asserts on the clk edge of the strobe at the middle of the stop bit, i.e. (9.5 or 10.5) x OSR strobes after the start-bit falling edge at rxd_s, +/-1 strobe.

Reset
REQ-030 rst=1 SHALL immediately force: state RX_IDLE, counters 0, synchronizer flops 1, rx_data 8'h00, rx_valid 0, rx_ready 0, parity_err 0, frame_err 0, overrun_err 0, rx_busy 0.
REQ-031 rst asserted mid-frame SHALL discard the frame; after release the block waits for a fresh falling edge.

Verification
REQ-032 OSR=16, no_parity=1, frame 0xA5 -> rx_data=8'hA5, one rx_valid pulse, rx_ready=1, all errors 0.
REQ-033 Even parity, 0x03 with parity bit 0 -> parity_err=0; repeat with parity bit 1 -> parity_err=1; odd parity, 0x03 with parity bit 1 -> parity_err=0.
REQ-034 rxd low for 4 strobes then high -> RX_IDLE after mid-start check, no rx_valid, rx_data unchanged.
REQ-035 Frame 0x00 with stop bit 0 -> rx_data=8'h00, frame_err=1, rx_valid pulses.
REQ-036 Frames 0x11 then 0x22 without rx_rd -> rx_data=8'h22, overrun_err=1; then rx_rd -> rx_ready=0, overrun_err=0.
REQ-037 rx_en=0 at data bit 4, and separately rst=1 at data bit 4 -> RX_IDLE, no rx_valid; next full frame 0x5A received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// Oversampling UART receiver: 2-flop rxd synchronizer, mid-bit sampling FSM, 8 data bits, optional parity.
// rx_valid pulses one clk after the mid-stop-bit strobe; rx_ready/overrun_err track consumer reads via rx_rd.
module uart_rx #(
  parameter int OSR = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_data_sample,
  input  logic       rx_en,
  input  logic       no_parity,
  input  logic       ev_parity,
  input  logic       rxd,
  input  logic       rx_rd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_ready,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun_err,
  output logic       rx_busy
);

  localparam int TW = $clog2(OSR);
  localparam logic [TW-1:0] TICK_MID = TW'(OSR / 2 - 1);
  localparam logic [TW-1:0] TICK_END = TW'(OSR - 1);

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

  rx_state_t     state, state_nxt;
  logic [TW-1:0] tick_cnt, tick_nxt;
  logic [2:0]    bit_cnt, bit_nxt;
  logic [7:0]    shift_q, shift_nxt;
  logic          par_err_q, par_err_nxt;
  logic          np_q, ev_q, cfg_load, complete;
  logic          rxd_meta, rxd_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxd_meta <= 1'b1;
      rxd_s    <= 1'b1;
    end else begin
      rxd_meta <= rxd;
      rxd_s    <= rxd_meta;
    end
  end

  always_comb begin
    state_nxt   = state;
    tick_nxt    = tick_cnt;
    bit_nxt     = bit_cnt;
    shift_nxt   = shift_q;
    par_err_nxt = par_err_q;
    cfg_load    = 1'b0;
    complete    = 1'b0;
    if (!rx_en) begin
      state_nxt = RX_IDLE;
      tick_nxt  = '0;
      bit_nxt   = '0;
    end else if (rx_data_sample) begin
      case (state)
        RX_IDLE: begin
          if (!rxd_s) begin
            state_nxt = RX_START;
            tick_nxt  = '0;
          end
        end
        RX_START: begin
          if (tick_cnt == TICK_MID) begin
            tick_nxt = '0;
            bit_nxt  = '0;
            if (!rxd_s) begin
              state_nxt   = RX_DATA;
              cfg_load    = 1'b1;
              par_err_nxt = 1'b0;
            end else begin
              state_nxt = RX_IDLE;
            end
          end else begin
            tick_nxt = tick_cnt + TW'(1);
          end
        end
        RX_DATA: begin
          if (tick_cnt == TICK_END) begin
            tick_nxt           = '0;
            shift_nxt[bit_cnt] = rxd_s;
            if (bit_cnt == 3'd7) begin
              bit_nxt   = '0;
              state_nxt = np_q ? RX_STOP : RX_PARITY;
            end else begin
              bit_nxt = bit_cnt + 3'd1;
            end
          end else begin
            tick_nxt = tick_cnt + TW'(1);
          end
        end
        RX_PARITY: begin
          if (tick_cnt == TICK_END) begin
            tick_nxt = '0;
            // even: data^parity must be 0; odd: must be 1
            par_err_nxt = (^shift_q) ^ rxd_s ^ ~ev_q;
            state_nxt   = RX_STOP;
          end else begin
            tick_nxt = tick_cnt + TW'(1);
          end
        end
        RX_STOP: begin
          if (tick_cnt == TICK_END) begin
            tick_nxt  = '0;
            complete  = 1'b1;
            state_nxt = RX_IDLE;
          end else begin
            tick_nxt = tick_cnt + TW'(1);
          end
        end
        default: state_nxt = RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RX_IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shift_q   <= '0;
      par_err_q <= 1'b0;
      np_q      <= 1'b1;
      ev_q      <= 1'b0;
    end else begin
      state     <= state_nxt;
      tick_cnt  <= tick_nxt;
      bit_cnt   <= bit_nxt;
      shift_q   <= shift_nxt;
      par_err_q <= par_err_nxt;
      if (cfg_load) begin
        np_q <= no_parity;
        ev_q <= ev_parity;
      end
    end
  end

  // completion beats a coincident read: byte stays ready, no overrun
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data     <= 8'h00;
      rx_valid    <= 1'b0;
      rx_ready    <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      rx_valid <= complete;
      if (complete) begin
        rx_data     <= shift_q;
        rx_ready    <= 1'b1;
        parity_err  <= par_err_q;
        frame_err   <= ~rxd_s;
        overrun_err <= ~rx_rd & (overrun_err | rx_ready);
      end else if (rx_rd) begin
        rx_ready    <= 1'b0;
        overrun_err <= 1'b0;
      end
    end
  end

  assign rx_busy = (state != RX_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames built bit-by-bit on rxd, expected results queued at send time
// and compared by a monitor on every rx_valid pulse.
module tb_uart_rx;
  localparam int OSR = 16;

  logic       clk, rst, rx_data_sample, rx_en, no_parity, ev_parity, rxd, rx_rd;
  logic [7:0] rx_data;
  logic       rx_valid, rx_ready, parity_err, frame_err, overrun_err, rx_busy;

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    logic       oerr;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   fails = 0;
  int   valid_cnt = 0;
  int   sdiv = 0;
  logic prev_valid = 1'b0;

  uart_rx #(.OSR(OSR)) dut (
    .clk(clk), .rst(rst), .rx_data_sample(rx_data_sample), .rx_en(rx_en),
    .no_parity(no_parity), .ev_parity(ev_parity), .rxd(rxd), .rx_rd(rx_rd),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .parity_err(parity_err), .frame_err(frame_err), .overrun_err(overrun_err),
    .rx_busy(rx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // one strobe every 4 clks, updated away from the rising edge
  initial rx_data_sample = 1'b0;
  always @(negedge clk) begin
    sdiv = (sdiv == 3) ? 0 : sdiv + 1;
    rx_data_sample = (sdiv == 0);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rx_valid) begin
      valid_cnt++;
      check("valid_single_clk", {31'd0, prev_valid}, 32'd0);
      check("exp_queue_nonempty", {31'd0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check("rx_data", {24'd0, rx_data}, {24'd0, e.data});
        check("parity_err", {31'd0, parity_err}, {31'd0, e.perr});
        check("frame_err", {31'd0, frame_err}, {31'd0, e.ferr});
        check("overrun_err", {31'd0, overrun_err}, {31'd0, e.oerr});
        check("rx_ready_on_valid", {31'd0, rx_ready}, 32'd1);
      end
    end
    prev_valid = rx_valid;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_strobes(input int n);
    repeat (n) begin
      @(posedge clk);
      while (!rx_data_sample) @(posedge clk);
    end
    #1;
  endtask

  task automatic push_exp(input logic [7:0] d, input logic p, input logic f, input logic o);
    exp_t e;
    e.data = d; e.perr = p; e.ferr = f; e.oerr = o;
    exp_q.push_back(e);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit use_par, input bit pbit, input bit stop);
    rxd = 1'b0;
    wait_strobes(OSR);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      wait_strobes(OSR);
    end
    if (use_par) begin
      rxd = pbit;
      wait_strobes(OSR);
    end
    rxd = stop;
    if (stop) begin
      wait_strobes(OSR);
    end else begin
      wait_strobes(OSR / 2 + 2);
      rxd = 1'b1;
      wait_strobes(OSR / 2 - 2);
    end
    rxd = 1'b1;
    wait_strobes(OSR);
  endtask

  task automatic send_partial(input logic [7:0] d);
    rxd = 1'b0;
    wait_strobes(OSR);
    for (int i = 0; i < 4; i++) begin
      rxd = d[i];
      wait_strobes(OSR);
    end
    rxd = d[4];
    wait_strobes(OSR / 2);
  endtask

  task automatic pulse_rd();
    @(posedge clk); #1 rx_rd = 1'b1;
    @(posedge clk); #1 rx_rd = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rx_en = 1'b1; no_parity = 1'b1; ev_parity = 1'b1; rxd = 1'b1; rx_rd = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rx_data", {24'd0, rx_data}, 32'h00);
    check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
    check("rst_parity_err", {31'd0, parity_err}, 32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    check("rst_overrun_err", {31'd0, overrun_err}, 32'd0);
    check("rst_rx_busy", {31'd0, rx_busy}, 32'd0);
    rst = 1'b0;
    wait_strobes(2);

    // plain 8N1 frame
    push_exp(8'hA5, 1'b0, 1'b0, 1'b0);
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
    check("a5_queue_drained", exp_q.size(), 32'd0);
    check("a5_valid_count", valid_cnt, 32'd1);
    check("a5_ready_held", {31'd0, rx_ready}, 32'd1);
    check("a5_idle_after", {31'd0, rx_busy}, 32'd0);
    pulse_rd();
    check("a5_ready_cleared", {31'd0, rx_ready}, 32'd0);
    check("a5_data_retained", {24'd0, rx_data}, 32'hA5);

    // parity: 0x03 has even weight
    no_parity = 1'b0; ev_parity = 1'b1;
    push_exp(8'h03, 1'b0, 1'b0, 1'b0);
    send_frame(8'h03, 1'b1, 1'b0, 1'b1);
    pulse_rd();
    push_exp(8'h03, 1'b1, 1'b0, 1'b0);
    send_frame(8'h03, 1'b1, 1'b1, 1'b1);
    pulse_rd();
    check("parity_err_holds_after_rd", {31'd0, parity_err}, 32'd1);
    ev_parity = 1'b0;
    push_exp(8'h03, 1'b0, 1'b0, 1'b0);
    send_frame(8'h03, 1'b1, 1'b1, 1'b1);
    pulse_rd();
    check("parity_valid_count", valid_cnt, 32'd4);

    // false start
    no_parity = 1'b1;
    rxd = 1'b0;
    wait_strobes(4);
    check("false_start_busy", {31'd0, rx_busy}, 32'd1);
    rxd = 1'b1;
    wait_strobes(OSR);
    check("false_start_idle", {31'd0, rx_busy}, 32'd0);
    check("false_start_no_valid", valid_cnt, 32'd4);
    check("false_start_data_kept", {24'd0, rx_data}, 32'h03);

    // framing error
    push_exp(8'h00, 1'b0, 1'b1, 1'b0);
    send_frame(8'h00, 1'b0, 1'b0, 1'b0);
    pulse_rd();
    check("frame_err_holds_after_rd", {31'd0, frame_err}, 32'd1);

    // overrun
    push_exp(8'h11, 1'b0, 1'b0, 1'b0);
    send_frame(8'h11, 1'b0, 1'b0, 1'b1);
    push_exp(8'h22, 1'b0, 1'b0, 1'b1);
    send_frame(8'h22, 1'b0, 1'b0, 1'b1);
    check("overrun_data", {24'd0, rx_data}, 32'h22);
    check("overrun_flag", {31'd0, overrun_err}, 32'd1);
    pulse_rd();
    check("overrun_rd_ready", {31'd0, rx_ready}, 32'd0);
    check("overrun_rd_flag", {31'd0, overrun_err}, 32'd0);

    // rx_en dropped mid-frame
    send_partial(8'hC3);
    check("en_abort_busy_before", {31'd0, rx_busy}, 32'd1);
    rx_en = 1'b0;
    @(posedge clk); #1;
    check("en_abort_idle", {31'd0, rx_busy}, 32'd0);
    check("en_abort_data_kept", {24'd0, rx_data}, 32'h22);
    rxd = 1'b1;
    wait_strobes(2);
    rx_en = 1'b1;
    wait_strobes(OSR);
    check("en_abort_no_valid", valid_cnt, 32'd7);
    push_exp(8'h5A, 1'b0, 1'b0, 1'b0);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1);
    check("en_recover_count", valid_cnt, 32'd8);
    pulse_rd();

    // reset mid-frame
    send_partial(8'hC3);
    check("rst_abort_busy_before", {31'd0, rx_busy}, 32'd1);
    rst = 1'b1;
    #1;
    check("rst_abort_idle", {31'd0, rx_busy}, 32'd0);
    check("rst_abort_data_cleared", {24'd0, rx_data}, 32'h00);
    rxd = 1'b1;
    wait_strobes(2);
    rst = 1'b0;
    wait_strobes(OSR);
    check("rst_abort_no_valid", valid_cnt, 32'd8);
    push_exp(8'h5A, 1'b0, 1'b0, 1'b0);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1);
    check("rst_recover_count", valid_cnt, 32'd9);
    check("rst_recover_data", {24'd0, rx_data}, 32'h5A);
    check("final_queue_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
